// File: rtl/timer_scheduler.sv
// Multiplexes NUM_SLOTS one-shot deadlines onto a single mtime/mtimecmp counter.
// The earliest active deadline is programmed into mtimecmp with a glitch-free
// hi(max) / lo / hi write sequence; expired slots are retired on the interrupt.
module timer_scheduler #(
  parameter  int unsigned NUM_SLOTS = 4,
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [SLOT_W-1:0]    cmd_slot,
  input  logic [63:0]          cmd_deadline,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] fired,
  output logic                 tm_reg_sel,
  output logic                 tm_h_sel,
  output logic [31:0]          tm_wdata,
  output logic                 tm_wenable,
  input  logic                 tm_int_pending
);

  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_SCAN,
    S_WR_HI_MAX,
    S_WR_LO,
    S_WR_HI,
    S_SETTLE,
    S_WAIT
  } state_t;

  state_t                 state;
  logic [SLOT_W-1:0]      scan_idx;
  logic                   scan_found;
  logic [63:0]            scan_min;
  logic [63:0]            prog_deadline;
  logic                   prog_valid;
  logic [NUM_SLOTS-1:0]   valid;
  logic [63:0]            deadline [NUM_SLOTS];

  logic                   base_found_c;
  logic [63:0]            base_min_c;
  logic [63:0]            cand_dl_c;
  logic                   take_c;
  logic                   next_found_c;
  logic [63:0]            next_min_c;
  logic                   expire_c;
  logic [NUM_SLOTS-1:0]   expire_mask_c;

  // Running-minimum step for the slot currently under scan; index 0 restarts it
  always_comb begin
    base_found_c = (scan_idx == '0) ? 1'b0 : scan_found;
    base_min_c   = (scan_idx == '0) ? '1 : scan_min;
    cand_dl_c    = deadline[scan_idx];
    // strict less-than keeps the lower index on a tie
    take_c       = valid[scan_idx] && (!base_found_c || (cand_dl_c < base_min_c));
    next_found_c = base_found_c | valid[scan_idx];
    next_min_c   = take_c ? cand_dl_c : base_min_c;
  end

  // Expiry condition and the set of slots retired by it
  always_comb begin
    expire_c      = prog_valid && tm_int_pending;
    expire_mask_c = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      expire_mask_c[i] = valid[i] && (deadline[i] <= prog_deadline);
    end
  end

  // Expiry has priority over a pending command
  assign cmd_ready   = (state == S_WAIT) && !expire_c;
  assign slot_active = valid;

  // Sequencer: scan table, program mtimecmp, then wait for commands or expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_SCAN;
      scan_idx      <= '0;
      scan_found    <= 1'b0;
      scan_min      <= '1;
      prog_deadline <= '1;
      prog_valid    <= 1'b0;
      valid         <= '0;
      fired         <= '0;
      tm_wenable    <= 1'b0;
      tm_wdata      <= '0;
      tm_reg_sel    <= 1'b1;
      tm_h_sel      <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        deadline[i] <= '0;
      end
    end else begin
      fired      <= '0;
      tm_wenable <= 1'b0;
      tm_reg_sel <= 1'b1;
      case (state)
        S_SCAN: begin
          if (scan_idx == LAST_IDX) begin
            prog_deadline <= next_min_c;
            prog_valid    <= next_found_c;
            scan_idx      <= '0;
            state         <= S_WR_HI_MAX;
            tm_wenable    <= 1'b1;
            tm_h_sel      <= 1'b1;
            tm_wdata      <= '1;
          end else begin
            scan_found <= next_found_c;
            scan_min   <= next_min_c;
            scan_idx   <= scan_idx + SLOT_W'(1);
          end
        end
        S_WR_HI_MAX: begin
          state      <= S_WR_LO;
          tm_wenable <= 1'b1;
          tm_h_sel   <= 1'b0;
          tm_wdata   <= prog_deadline[31:0];
        end
        S_WR_LO: begin
          state      <= S_WR_HI;
          tm_wenable <= 1'b1;
          tm_h_sel   <= 1'b1;
          tm_wdata   <= prog_deadline[63:32];
        end
        S_WR_HI: begin
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (expire_c) begin
            valid <= valid & ~expire_mask_c;
            fired <= expire_mask_c;
            state <= S_SCAN;
          end else if (cmd_valid) begin
            if (cmd_op) begin
              valid[cmd_slot] <= 1'b0;
            end else begin
              valid[cmd_slot]    <= 1'b1;
              deadline[cmd_slot] <= cmd_deadline;
            end
            state <= S_SCAN;
          end
        end
        default: begin
          state <= S_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler with a behavioural mtime/mtimecmp counter.
module tb_timer_scheduler;

  localparam int unsigned NS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [1:0]    cmd_slot = '0;
  logic [63:0]   cmd_deadline = '0;
  logic [NS-1:0] slot_active;
  logic [NS-1:0] fired;
  logic          tm_reg_sel;
  logic          tm_h_sel;
  logic [31:0]   tm_wdata;
  logic          tm_wenable;
  logic          tm_int_pending;

  logic [63:0]   mtime = '0;
  logic [63:0]   mtimecmp = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [NS-1:0] mask;
    logic [63:0]   lo;
    logic [63:0]   hi;
  } fire_t;

  wr_t   wr_q[$];
  fire_t fire_q[$];

  logic [NS-1:0] m_valid = '0;
  logic [63:0]   m_dl [NS];

  timer_scheduler #(.NUM_SLOTS(NS)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_slot      (cmd_slot),
    .cmd_deadline  (cmd_deadline),
    .slot_active   (slot_active),
    .fired         (fired),
    .tm_reg_sel    (tm_reg_sel),
    .tm_h_sel      (tm_h_sel),
    .tm_wdata      (tm_wdata),
    .tm_wenable    (tm_wenable),
    .tm_int_pending(tm_int_pending)
  );

  always #5 clk = ~clk;

  // Counter: mtime cleared by system reset, mtimecmp only by writes
  always @(posedge clk) begin
    if (rst) mtime <= '0;
    else     mtime <= mtime + 64'd1;
    if (tm_wenable && tm_reg_sel) begin
      if (tm_h_sel) mtimecmp[63:32] <= tm_wdata;
      else          mtimecmp[31:0]  <= tm_wdata;
    end
  end

  assign tm_int_pending = (mtime >= mtimecmp);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops expected writes and fire pulses as they appear
  always @(negedge clk) begin
    if (tm_wenable) begin
      if (wr_q.size() == 0) begin
        check_eq("wr_unexpected", 64'(tm_wdata), 64'hDEAD);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check_eq("wr_addr", 64'({tm_reg_sel, tm_h_sel}), 64'(e.addr));
        check_eq("wr_data", 64'(tm_wdata), 64'(e.data));
      end
    end
    if (fired != '0) begin
      if (fire_q.size() == 0) begin
        check_eq("fire_unexpected", 64'(fired), 64'd0);
      end else begin
        fire_t f;
        f = fire_q.pop_front();
        check_eq("fire_mask", 64'(fired), 64'(f.mask));
        check_eq("fire_time", 64'(mtime >= f.lo && mtime <= f.hi), 64'd1);
      end
    end
  end

  // Expected mtimecmp program sequence for the model's earliest deadline
  task automatic push_prog();
    logic [63:0] mn;
    mn = '1;
    for (int i = 0; i < NS; i++) if (m_valid[i] && m_dl[i] < mn) mn = m_dl[i];
    wr_q.push_back('{addr: 2'b11, data: 32'hFFFF_FFFF});
    wr_q.push_back('{addr: 2'b10, data: mn[31:0]});
    wr_q.push_back('{addr: 2'b11, data: mn[63:32]});
  endtask

  task automatic expect_fire(input logic [NS-1:0] mask, input logic [63:0] lo, input logic [63:0] hi);
    fire_q.push_back('{mask: mask, lo: lo, hi: hi});
    m_valid = m_valid & ~mask;
    push_prog();
  endtask

  task automatic do_reset();
    wr_q.delete();
    fire_q.delete();
    rst = 1'b1;
    m_valid = '0;
    repeat (2) @(posedge clk);
    push_prog();
    #1 rst = 1'b0;
  endtask

  task automatic send_cmd(input logic op, input int slot, input logic [63:0] dl,
                          output logic [63:0] acc_mtime);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_slot = 2'(slot);
    cmd_deadline = dl;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    acc_mtime = mtime;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (op) m_valid[slot] = 1'b0;
    else begin
      m_valid[slot] = 1'b1;
      m_dl[slot] = dl;
    end
    push_prog();
    check_eq("slot_active", 64'(slot_active), 64'(m_valid));
  endtask

  task automatic wait_mtime(input logic [63:0] target);
    int n;
    n = 0;
    while (mtime < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("mtime_reached", 64'(mtime >= target), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || fire_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("queues_drained", 64'(wr_q.size() + fire_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_again", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] am;

    // Reset release: writes in cycles 5..7, ready first in cycle 9
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check_eq($sformatf("rel_wen_c%0d", c), 64'(tm_wenable), 64'(c >= 5 && c <= 7));
      check_eq($sformatf("rel_rdy_c%0d", c), 64'(cmd_ready), 64'(c == 9));
      check_eq("rel_fired", 64'(fired), 64'd0);
    end
    check_eq("rel_mtimecmp", mtimecmp, '1);

    // Single deadline at 100
    send_cmd(1'b0, 2, 64'd100, am);
    wait_ready();
    check_eq("cmp_100", mtimecmp, 64'd100);
    expect_fire(4'b0100, 64'd100, 64'd102);
    drain();
    check_eq("s2_active", 64'(slot_active), 64'd0);
    check_eq("s2_cmp", mtimecmp, '1);

    // Later deadline then earlier one
    do_reset();
    send_cmd(1'b0, 0, 64'd500, am);
    wait_ready();
    check_eq("cmp_500", mtimecmp, 64'd500);
    send_cmd(1'b0, 1, 64'd300, am);
    wait_ready();
    check_eq("cmp_300", mtimecmp, 64'd300);
    expect_fire(4'b0010, 64'd300, 64'd302);
    expect_fire(4'b0001, 64'd500, 64'd502);
    wait_mtime(64'd320);
    check_eq("cmp_back_500", mtimecmp, 64'd500);
    check_eq("s3_active_mid", 64'(slot_active), 64'b0001);
    drain();
    check_eq("s3_cmp", mtimecmp, '1);

    // Cancel before expiry
    do_reset();
    send_cmd(1'b0, 3, 64'd400, am);
    send_cmd(1'b1, 3, 64'd0, am);
    wait_mtime(64'd600);
    drain();
    check_eq("s4_active", 64'(slot_active), 64'd0);
    check_eq("s4_cmp", mtimecmp, '1);

    // Past deadline and tie
    do_reset();
    send_cmd(1'b0, 1, 64'd250, am);
    send_cmd(1'b0, 2, 64'd250, am);
    wait_mtime(64'd50);
    send_cmd(1'b0, 0, 64'd5, am);
    expect_fire(4'b0001, am + 64'd10, am + 64'd10);
    expect_fire(4'b0110, 64'd250, 64'd252);
    drain();
    check_eq("s5_active", 64'(slot_active), 64'd0);
    check_eq("s5_cmp", mtimecmp, '1);

    // Reset in the middle of a program sequence
    do_reset();
    send_cmd(1'b0, 1, 64'd700, am);
    wr_q.delete(wr_q.size() - 1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(tm_wenable && !tm_h_sel) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_eq("saw_wr_lo", 64'(tm_wenable && !tm_h_sel), 64'd1);
    end
    #1 rst = 1'b1;
    #1;
    check_eq("mr_wen", 64'(tm_wenable), 64'd0);
    check_eq("mr_wdata", 64'(tm_wdata), 64'd0);
    check_eq("mr_regsel", 64'(tm_reg_sel), 64'd1);
    check_eq("mr_hsel", 64'(tm_h_sel), 64'd0);
    check_eq("mr_ready", 64'(cmd_ready), 64'd0);
    check_eq("mr_fired", 64'(fired), 64'd0);
    check_eq("mr_active", 64'(slot_active), 64'd0);
    do_reset();
    wait_mtime(64'd720);
    drain();
    check_eq("s6_cmp", mtimecmp, '1);
    check_eq("s6_active", 64'(slot_active), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
